// File: rtl/exe_stage.sv
// EXE pipeline stage: holds the instruction handed over by ID, runs an
// iterative restoring divider for divide ops, and hands results to MEM
// through a valid/allowin handshake. Also exports the hazard view for the
// Stall unit.
module exe_stage #(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_to_EXE_valid,
    output logic             EXE_allowin,
    input  logic [31:0]      in_pc,
    input  logic [DIV_W-1:0] in_alu_result,
    input  logic [DIV_W-1:0] in_src1,
    input  logic [DIV_W-1:0] in_src2,
    input  logic [4:0]       in_dest,
    input  logic             in_reg_we,
    input  logic             in_sel_MEM_gene,
    input  logic             in_div_en,
    input  logic             in_div_signed,
    input  logic             in_div_sel_rem,
    input  logic             MEM_allowin,
    input  logic             flush,
    output logic             EXE_to_MEM_valid,
    output logic [31:0]      out_pc,
    output logic [DIV_W-1:0] out_result,
    output logic [4:0]       out_dest,
    output logic             out_reg_we,
    output logic             out_sel_MEM_gene,
    output logic [6:0]       EXE_to_ST_bus,
    output logic             div_busy
);

    localparam int unsigned CNT_W = $clog2(DIV_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } div_state_t;

    div_state_t state_q, state_d;

    logic             exe_valid;
    logic             exe_ready_go;
    logic [DIV_W-1:0] alu_result_q;
    logic [DIV_W-1:0] src1_q;
    logic [DIV_W-1:0] src2_q;
    logic             div_en_q;
    logic             div_signed_q;
    logic             div_sel_rem_q;

    // Divider working registers: rem_acc is the partial remainder, dq shifts
    // the dividend out of its top while quotient bits shift in at the bottom.
    logic [DIV_W-1:0] rem_acc;
    logic [DIV_W-1:0] dq;
    logic [DIV_W-1:0] divisor_q;
    logic [DIV_W-1:0] quo_q;
    logic [DIV_W-1:0] rem_q;
    logic [CNT_W-1:0] count;

    logic [DIV_W:0]   shifted;
    logic             ge;
    logic [DIV_W-1:0] rem_next;
    logic [DIV_W-1:0] dq_next;
    logic             src1_neg;
    logic             src2_neg;
    logic [DIV_W-1:0] abs1;
    logic [DIV_W-1:0] abs2;
    logic             quo_neg;
    logic [DIV_W-1:0] quo_fix;
    logic [DIV_W-1:0] rem_fix;
    logic             div_by_zero;
    logic             last_iter;

    assign exe_ready_go     = ~div_en_q | (state_q == S_DONE);
    assign EXE_allowin      = ~flush & (~exe_valid | (exe_ready_go & MEM_allowin));
    assign EXE_to_MEM_valid = exe_valid & exe_ready_go;
    assign out_result       = div_en_q ? (div_sel_rem_q ? rem_q : quo_q) : alu_result_q;
    assign EXE_to_ST_bus    = {out_dest, exe_valid, out_sel_MEM_gene};
    assign div_busy         = (state_q == S_RUN);

    // One restoring step plus operand magnitude and result sign fix-up
    always_comb begin
        shifted     = {rem_acc, dq[DIV_W-1]};
        ge          = (shifted >= {1'b0, divisor_q});
        // When ge, the difference is below the divisor so it fits in DIV_W bits
        rem_next    = ge ? (shifted[DIV_W-1:0] - divisor_q) : shifted[DIV_W-1:0];
        dq_next     = {dq[DIV_W-2:0], ge};
        src1_neg    = div_signed_q & src1_q[DIV_W-1];
        src2_neg    = div_signed_q & src2_q[DIV_W-1];
        abs1        = src1_neg ? -src1_q : src1_q;
        abs2        = src2_neg ? -src2_q : src2_q;
        quo_neg     = src1_neg ^ src2_neg;
        quo_fix     = quo_neg ? -dq_next : dq_next;
        rem_fix     = src1_neg ? -rem_next : rem_next;
        div_by_zero = (src2_q == '0);
        last_iter   = (count == CNT_W'(DIV_W - 1));
    end

    // Divider FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divider FSM next state; flush overrides any progress
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (exe_valid && div_en_q)                  state_d = S_RUN;
            S_RUN:   if (last_iter)                              state_d = S_DONE;
            S_DONE:  if (EXE_to_MEM_valid && MEM_allowin)        state_d = S_IDLE;
            default:                                             state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Divider datapath: operand load on start, one quotient bit per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_acc   <= '0;
            dq        <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            count     <= '0;
        end else if (state_q == S_IDLE && state_d == S_RUN) begin
            rem_acc   <= '0;
            dq        <= abs1;
            divisor_q <= abs2;
            count     <= '0;
        end else if (state_q == S_RUN && !flush) begin
            rem_acc <= rem_next;
            dq      <= dq_next;
            count   <= count + 1'b1;
            if (last_iter) begin
                // Divide by zero bypasses the sign fix-up: all-ones quotient, raw dividend
                quo_q <= div_by_zero ? '1 : quo_fix;
                rem_q <= div_by_zero ? src1_q : rem_fix;
            end
        end
    end

    // Pipeline valid bit and instruction field latch
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_valid        <= 1'b0;
            out_pc           <= '0;
            alu_result_q     <= '0;
            src1_q           <= '0;
            src2_q           <= '0;
            out_dest         <= '0;
            out_reg_we       <= 1'b0;
            out_sel_MEM_gene <= 1'b0;
            div_en_q         <= 1'b0;
            div_signed_q     <= 1'b0;
            div_sel_rem_q    <= 1'b0;
        end else begin
            if (flush) begin
                exe_valid <= 1'b0;
            end else if (EXE_allowin) begin
                exe_valid <= ID_to_EXE_valid;
            end
            if (ID_to_EXE_valid && EXE_allowin) begin
                out_pc           <= in_pc;
                alu_result_q     <= in_alu_result;
                src1_q           <= in_src1;
                src2_q           <= in_src2;
                out_dest         <= in_dest;
                out_reg_we       <= in_reg_we;
                out_sel_MEM_gene <= in_sel_MEM_gene;
                div_en_q         <= in_div_en;
                div_signed_q     <= in_div_signed;
                div_sel_rem_q    <= in_div_sel_rem;
            end
        end
    end

endmodule
